retention_pwr_ctrl: RTL and testbench

- Sequences one power-gated domain built from RSDFFAR-style retention flops (RETN-gated clock, asynchronous RSTB, always-on VDDG).
- Drives the domain clock enable, isolation, retention control, domain reset and power-switch request.
- Uses a four-phase power-down/power-up handshake with the always-on system controller.
- Sits in the always-on domain next to the header-switch cluster.

---
 rtl/retention_pwr_ctrl.sv | 163 ++++++++++++++++
 tb/tb_retention_pwr_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/retention_pwr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : retention_pwr_ctrl
//  Description : Always-on sequencer for one power-gated domain built from
//                retention flops. Orders clock gating, isolation, retention
//                save/restore and the power-switch request, and handshakes
//                with the system controller through pd_req / pd_ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module retention_pwr_ctrl #(
  parameter int CNT_W        = 8,
  parameter int CLK_STOP_CYC = 2,
  parameter int SAVE_CYC     = 2,
  parameter int RESTORE_CYC  = 2,
  parameter int PSW_TIMEOUT  = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic pd_req,
  input  logic psw_ack,
  output logic pd_ack,
  output logic busy,
  output logic clk_en,
  output logic iso,
  output logic retn,
  output logic dom_rstb,
  output logic sleep,
  output logic err
);

  typedef enum logic [3:0] {
    ST_ON       = 4'd0,
    ST_CLK_STOP = 4'd1,
    ST_ISO_ON   = 4'd2,
    ST_SAVE     = 4'd3,
    ST_PSW_OFF  = 4'd4,
    ST_OFF      = 4'd5,
    ST_PSW_ON   = 4'd6,
    ST_RESTORE  = 4'd7,
    ST_ISO_OFF  = 4'd8
  } state_t;

  // Counter preloads: each timed phase counts down from N-1 to 0.
  localparam logic [CNT_W-1:0] C_CLK_STOP_LD = CNT_W'(CLK_STOP_CYC - 1);
  localparam logic [CNT_W-1:0] C_SAVE_LD     = CNT_W'(SAVE_CYC - 1);
  localparam logic [CNT_W-1:0] C_RESTORE_LD  = CNT_W'(RESTORE_CYC - 1);
  localparam logic [CNT_W-1:0] C_TIMEOUT_LD  = CNT_W'(PSW_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_set;

  // Domain-side drive per state, packed as {clk_en, iso, retn, sleep}.
  function automatic logic [3:0] drive_of(input state_t s);
    logic [3:0] d;
    case (s)
      ST_ON:       d = 4'b1010;
      ST_CLK_STOP: d = 4'b0010;
      ST_ISO_ON:   d = 4'b0110;
      ST_SAVE:     d = 4'b0100;
      ST_PSW_OFF:  d = 4'b0101;
      ST_OFF:      d = 4'b0101;
      ST_PSW_ON:   d = 4'b0100;
      ST_RESTORE:  d = 4'b0110;
      ST_ISO_OFF:  d = 4'b0010;
      default:     d = 4'b1010;
    endcase
    return d;
  endfunction

  // Next-state, counter and timeout detection; switch waits never give up,
  // they only flag the overrun and keep holding the current drive.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    err_set   = 1'b0;
    case (state)
      ST_ON: begin
        if (pd_req) begin
          state_nxt = ST_CLK_STOP;
          cnt_nxt   = C_CLK_STOP_LD;
        end
      end
      ST_CLK_STOP: begin
        if (cnt == '0) state_nxt = ST_ISO_ON;
        else           cnt_nxt   = cnt - C_ONE;
      end
      ST_ISO_ON: begin
        state_nxt = ST_SAVE;
        cnt_nxt   = C_SAVE_LD;
      end
      ST_SAVE: begin
        if (cnt == '0) begin
          state_nxt = ST_PSW_OFF;
          cnt_nxt   = C_TIMEOUT_LD;
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      ST_PSW_OFF: begin
        if (psw_ack)        state_nxt = ST_OFF;
        else if (cnt == '0) err_set   = 1'b1;
        else                cnt_nxt   = cnt - C_ONE;
      end
      ST_OFF: begin
        if (!pd_req) begin
          state_nxt = ST_PSW_ON;
          cnt_nxt   = C_TIMEOUT_LD;
        end
      end
      ST_PSW_ON: begin
        if (!psw_ack) begin
          state_nxt = ST_RESTORE;
          cnt_nxt   = C_RESTORE_LD;
        end else if (cnt == '0) begin
          err_set = 1'b1;
        end else begin
          cnt_nxt = cnt - C_ONE;
        end
      end
      ST_RESTORE: begin
        if (cnt == '0) state_nxt = ST_ISO_OFF;
        else           cnt_nxt   = cnt - C_ONE;
      end
      ST_ISO_OFF: begin
        state_nxt = ST_ON;
      end
      default: begin
        state_nxt = ST_ON;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register with outputs decoded from the next state so every output
  // is a flop aligned with the state it describes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                       <= ST_ON;
      cnt                         <= '0;
      err                         <= 1'b0;
      {clk_en, iso, retn, sleep}  <= 4'b1010;
      pd_ack                      <= 1'b0;
      busy                        <= 1'b0;
      dom_rstb                    <= 1'b0;
    end else begin
      state                       <= state_nxt;
      cnt                         <= cnt_nxt;
      if (err_set) err            <= 1'b1;
      {clk_en, iso, retn, sleep}  <= drive_of(state_nxt);
      pd_ack                      <= (state_nxt == ST_OFF);
      busy                        <= (state_nxt != ST_ON) && (state_nxt != ST_OFF);
      // Domain reset is only a power-on/RST event; retention relies on it
      // staying released through OFF.
      dom_rstb                    <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_retention_pwr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_retention_pwr_ctrl
//  Description : Self-checking bench for retention_pwr_ctrl with a phase-table
//                reference model, a delayed power-switch model and a simple
//                retention-flop model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_retention_pwr_ctrl;

  localparam int CNT_W = 8;
  localparam int CSC   = 2;
  localparam int SVC   = 2;
  localparam int RSC   = 2;
  localparam int PTO   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pd_req = 1'b0;
  logic psw_ack = 1'b0;
  logic pd_ack, busy, clk_en, iso, retn, dom_rstb, sleep, err;

  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase index along the power sequence and cycles spent in it.
  // 0 ON, 1 CLK_STOP, 2 ISO_ON, 3 SAVE, 4 PSW_OFF, 5 OFF, 6 PSW_ON, 7 RESTORE, 8 ISO_OFF
  int   m_ph  = 0;
  int   m_age = 0;
  bit   m_err = 1'b0;
  bit   m_rstb = 1'b0;

  // Switch model: acknowledge follows sleep three cycles later.
  logic [3:0] sh = 4'b0000;
  int   ack_mode  = 0;      // 0 follow sleep, 1 forced, 2 follow sleep with glitches
  logic ack_force = 1'b0;
  bit   ret_q     = 1'b0;   // retention flop content, lost if unpowered without retention

  retention_pwr_ctrl #(
    .CNT_W(CNT_W), .CLK_STOP_CYC(CSC), .SAVE_CYC(SVC),
    .RESTORE_CYC(RSC), .PSW_TIMEOUT(PTO)
  ) dut (
    .clk(clk), .rst(rst), .pd_req(pd_req), .psw_ack(psw_ack),
    .pd_ack(pd_ack), .busy(busy), .clk_en(clk_en), .iso(iso),
    .retn(retn), .dom_rstb(dom_rstb), .sleep(sleep), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int dur_of(input int p);
    case (p)
      1: return CSC;
      2: return 1;
      3: return SVC;
      7: return RSC;
      8: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_age = 0; m_err = 1'b0; m_rstb = 1'b0;
  endtask

  task automatic model_step(input logic req, input logic ack);
    if (rst) begin
      model_reset();
    end else begin
      m_rstb = 1'b1;
      case (m_ph)
        0: if (req) begin m_ph = 1; m_age = 0; end
        4: begin
          if (ack) begin m_ph = 5; m_age = 0; end
          else begin m_age++; if (m_age >= PTO) m_err = 1'b1; end
        end
        5: if (!req) begin m_ph = 6; m_age = 0; end
        6: begin
          if (!ack) begin m_ph = 7; m_age = 0; end
          else begin m_age++; if (m_age >= PTO) m_err = 1'b1; end
        end
        default: begin
          m_age++;
          if (m_age >= dur_of(m_ph)) begin
            m_ph  = (m_ph == 8) ? 0 : m_ph + 1;
            m_age = 0;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clk_en"},   clk_en,   m_ph == 0);
    chk({tag, ".iso"},      iso,      !(m_ph == 0 || m_ph == 1 || m_ph == 8));
    chk({tag, ".retn"},     retn,     !(m_ph >= 3 && m_ph <= 6));
    chk({tag, ".sleep"},    sleep,    m_ph == 4 || m_ph == 5);
    chk({tag, ".pd_ack"},   pd_ack,   m_ph == 5);
    chk({tag, ".busy"},     busy,     m_ph != 0 && m_ph != 5);
    chk({tag, ".dom_rstb"}, dom_rstb, m_rstb);
    chk({tag, ".err"},      err,      m_err);
    chk({tag, ".inv_retn_clken"}, retn === 1'b0 && clk_en === 1'b1, 1'b0);
    chk({tag, ".inv_sleep_retn"}, sleep === 1'b1 && retn === 1'b1,  1'b0);
    chk({tag, ".inv_iso_sleep"},  iso === 1'b0 && sleep === 1'b1,   1'b0);
  endtask

  // One clock: model sees the same inputs the DUT sampled, then the switch
  // model updates its acknowledge and all outputs are compared.
  task automatic tick(input string tag);
    @(posedge clk);
    model_step(pd_req, psw_ack);
    #1;
    sh = {sh[2:0], sleep};
    case (ack_mode)
      0:       psw_ack = sh[3];
      1:       psw_ack = ack_force;
      default: psw_ack = sh[3] ^ ($urandom_range(19) == 0);
    endcase
    if (psw_ack === 1'b1 && retn === 1'b1) ret_q = 1'b0;
    check_all(tag);
  endtask

  initial begin
    int f_ce, f_iso, f_rt, f_sl, f_ack, f_err, n_ack;
    bit done;

    // Cold reset
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("reset_async");
    repeat (3) tick("reset");
    @(negedge clk) rst = 1'b0;
    #1 chk("rstb_low_after_release", dom_rstb, 1'b0);
    tick("release");
    chk("rstb_high_first_edge", dom_rstb, 1'b1);
    repeat (2) tick("idle_on");

    // Full power-down; cycle c is the value after edge c-1, edge 0 samples pd_req
    ret_q = 1'b1;
    pd_req = 1'b1;
    f_ce = -1; f_iso = -1; f_rt = -1; f_sl = -1; f_ack = -1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick("pdown");
      if (f_ce  < 0 && clk_en === 1'b0) f_ce  = k + 1;
      if (f_iso < 0 && iso    === 1'b1) f_iso = k + 1;
      if (f_rt  < 0 && retn   === 1'b0) f_rt  = k + 1;
      if (f_sl  < 0 && sleep  === 1'b1) f_sl  = k + 1;
      if (pd_ack === 1'b1) begin f_ack = k + 1; done = 1'b1; end
    end
    chki("pd_clk_en_fall_cycle", f_ce, 1);
    chki("pd_iso_rise_cycle", f_iso, 3);
    chki("pd_retn_fall_cycle", f_rt, 4);
    chki("pd_sleep_rise_cycle", f_sl, 6);
    chki("pd_ack_rise_cycle", f_ack, 10);
    repeat (3) tick("off_hold");
    chk("off_pd_ack_held", pd_ack, 1'b1);

    // Power-up from OFF
    pd_req = 1'b0;
    f_ce = -1; f_iso = -1; f_rt = -1; f_sl = -1; done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      tick("pup");
      if (f_sl  < 0 && sleep  === 1'b0) f_sl  = k + 1;
      if (f_rt  < 0 && retn   === 1'b1) f_rt  = k + 1;
      if (f_iso < 0 && iso    === 1'b0) f_iso = k + 1;
      if (clk_en === 1'b1) begin f_ce = k + 1; done = 1'b1; end
    end
    chki("pu_sleep_fall_to_retn", f_rt - f_sl, 4);
    chki("pu_retn_to_iso_release", f_iso - f_rt, 2);
    chki("pu_iso_release_to_clk_en", f_ce - f_iso, 1);
    chk("pu_retained_q", ret_q, 1'b1);
    repeat (2) tick("on_again");

    // Switch timeout: acknowledge held low while sleeping
    ack_mode = 1; ack_force = 1'b0; psw_ack = 1'b0;
    pd_req = 1'b1;
    f_sl = -1; f_err = -1;
    for (int k = 0; k < 85; k++) begin
      tick("timeout");
      if (f_sl  < 0 && sleep === 1'b1) f_sl  = k;
      if (f_err < 0 && err   === 1'b1) f_err = k;
    end
    chki("to_err_delay", f_err - f_sl, 64);
    chk("to_still_sleep", sleep, 1'b1);
    chk("to_no_pd_ack", pd_ack, 1'b0);
    ack_force = 1'b1; psw_ack = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 5 && !done; k++) begin
      tick("to_late_ack");
      if (pd_ack === 1'b1) done = 1'b1;
    end
    chk("to_reach_off", pd_ack, 1'b1);
    chk("to_err_sticky", err, 1'b1);

    // Reset in the middle of power-up
    ack_mode = 0;
    pd_req = 1'b0;
    repeat (3) tick("pre_mid_rst");
    #2 rst = 1'b1;
    model_reset();
    #1 check_all("rst_mid");
    chk("rst_mid_err_clear", err, 1'b0);
    chk("rst_mid_rstb_low", dom_rstb, 1'b0);
    repeat (2) tick("rst_mid_hold");
    @(negedge clk) rst = 1'b0;
    repeat (6) tick("after_mid_rst");

    // Request reversal one cycle into SAVE
    pd_req = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick("rev_down");
      if (retn === 1'b0) done = 1'b1;
    end
    chk("rev_reached_save", done, 1'b1);
    tick("rev_save");
    pd_req = 1'b0;
    n_ack = 0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      tick("rev_cycle");
      if (pd_ack === 1'b1) n_ack++;
      if (n_ack > 0 && clk_en === 1'b1) done = 1'b1;
    end
    chki("rev_pd_ack_len", n_ack, 1);
    chk("rev_back_on", clk_en, 1'b1);

    // Random request/acknowledge traffic
    ack_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(23) == 0) pd_req = ~pd_req;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
